dcache_write_buffer: RTL



---
 rtl/dcache_write_buffer_pkg.sv | 14 +
 rtl/dcache_write_buffer_storage.sv | 87 ++++++++
 rtl/dcache_write_buffer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dcache_write_buffer_pkg.sv
// Shared types for the D-cache write-back buffer: line/tag widths and controller states.
package dcache_write_buffer_pkg;

  typedef logic [127:0] lc3b_line;
  typedef logic [11:0]  lc3b_tag;

  typedef enum logic [1:0] {
    IDLE,
    RD_MEM,
    DRAIN,
    RESP
  } wb_state_t;

endpackage

// File: rtl/dcache_write_buffer_storage.sv
// Circular line store with tag match: update on the edge after coalesce/alloc/pop; match is combinational.
// No internal backpressure; the controller must never alloc when full or pop when empty.
module dcache_write_buffer_storage
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  lc3b_tag  lookup_tag,
  input  logic     lock,
  input  logic     coalesce,
  input  logic     alloc,
  input  logic     pop,
  input  lc3b_line wdata,
  output logic     wr_hit,
  output logic     rd_hit,
  output lc3b_line rd_data,
  output lc3b_tag  head_tag,
  output lc3b_line head_data,
  output logic     full,
  output logic     empty
);

  localparam int PW = $clog2(DEPTH);

  lc3b_tag          tags  [DEPTH];
  lc3b_line         lines [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    head, tail, idx, rd_idx, wr_idx;
  logic [PW:0]      count;

  // Scan oldest to youngest so the last match wins; a locked head never takes a coalesce.
  always_comb begin
    rd_hit = 1'b0;
    wr_hit = 1'b0;
    rd_idx = head;
    wr_idx = head;
    idx    = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid[idx] && tags[idx] == lookup_tag) begin
        rd_hit = 1'b1;
        rd_idx = idx;
        if (!(lock && idx == head)) begin
          wr_hit = 1'b1;
          wr_idx = idx;
        end
      end
    end
  end

  assign rd_data   = lines[rd_idx];
  assign head_tag  = tags[head];
  assign head_data = lines[head];
  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);

  always_ff @(posedge clk) begin
    if (coalesce) begin
      lines[wr_idx] <= wdata;
    end else if (alloc) begin
      tags[tail]  <= lookup_tag;
      lines[tail] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (alloc) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      count <= count + {{PW{1'b0}}, alloc} - {{PW{1'b0}}, pop};
    end
  end

endmodule

// File: rtl/dcache_write_buffer.sv
// Write-back buffer between L1 D-cache and arbiter port B; writes/read hits ack one cycle after accept,
// read misses ack the cycle after pmem_resp; a write to a full buffer stalls until the head drains.
module dcache_write_buffer
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [15:0]  mem_address,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic         wb_empty
);

  wb_state_t state, state_n;
  lc3b_tag   req_tag, head_tag;
  lc3b_line  rd_data, head_data;
  logic      wr_hit, rd_hit, full;
  logic      coalesce, alloc, pop, start_rd, start_drain, load_hit, rd_done;

  // Line offset is meaningless for whole-line transfers.
  logic unused_offset;
  assign unused_offset = ^mem_address[3:0];
  assign req_tag       = mem_address[15:4];

  dcache_write_buffer_storage #(.DEPTH(DEPTH)) u_storage (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_tag (req_tag),
    .lock       (state == DRAIN),
    .coalesce   (coalesce),
    .alloc      (alloc),
    .pop        (pop),
    .wdata      (mem_wdata),
    .wr_hit     (wr_hit),
    .rd_hit     (rd_hit),
    .rd_data    (rd_data),
    .head_tag   (head_tag),
    .head_data  (head_data),
    .full       (full),
    .empty      (wb_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    coalesce    = 1'b0;
    alloc       = 1'b0;
    pop         = 1'b0;
    start_rd    = 1'b0;
    start_drain = 1'b0;
    load_hit    = 1'b0;
    rd_done     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_write) begin
          if (wr_hit) begin
            coalesce = 1'b1;
            state_n  = RESP;
          end else if (!full) begin
            alloc   = 1'b1;
            state_n = RESP;
          end else begin
            start_drain = 1'b1;
            state_n     = DRAIN;
          end
        end else if (mem_read) begin
          if (rd_hit) begin
            load_hit = 1'b1;
            state_n  = RESP;
          end else begin
            start_rd = 1'b1;
            state_n  = RD_MEM;
          end
        end else if (!wb_empty) begin
          start_drain = 1'b1;
          state_n     = DRAIN;
        end
      end
      RD_MEM: begin
        if (pmem_resp) begin
          rd_done = 1'b1;
          state_n = RESP;
        end
      end
      DRAIN: begin
        // A waiting write is only taken on the completing edge, using pre-pop occupancy.
        if (pmem_resp) begin
          pop     = 1'b1;
          state_n = IDLE;
          if (mem_write && wr_hit) begin
            coalesce = 1'b1;
            state_n  = RESP;
          end else if (mem_write && !full) begin
            alloc   = 1'b1;
            state_n = RESP;
          end
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_resp     <= 1'b0;
      mem_rdata    <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      mem_resp <= (state_n == RESP);
      if (start_rd) begin
        pmem_read    <= 1'b1;
        pmem_address <= {req_tag, 4'h0};
      end else if (start_drain) begin
        pmem_write   <= 1'b1;
        pmem_address <= {head_tag, 4'h0};
        pmem_wdata   <= head_data;
      end
      if (rd_done) begin
        pmem_read <= 1'b0;
        mem_rdata <= pmem_rdata;
      end
      if (load_hit) mem_rdata  <= rd_data;
      if (pop)      pmem_write <= 1'b0;
    end
  end

endmodule
